fpu_issue_ctrl: RTL and testbench
=================================

FPU_ISSUE_CTRL -- requirements
Module: fpu_issue_ctrl

Interface
REQ-001 Parameter TAG_WIDTH, default 4, width of the request/response tag.
REQ-002 Parameter RESP_DEPTH, default 8, response FIFO depth and maximum operations in flight; power of two, >= 4.
REQ-003 Port clk_i  in  1  clock; one clock domain; all state changes on the rising edge.
REQ-004 Port rst_ni  in  1  reset; asynchronous assertion, active-low.
REQ-005 Port req_valid_i  in  1 / req_ready_o  out  1  request handshake; transfer when both are high.
REQ-006 Port req_op_i  in  C_CMD  FPU command / req_rm_i  in  C_RM  rounding mode / req_prec_i  in  C_PC  div/sqrt precision / req_tag_i  in  TAG_WIDTH  request tag.
REQ-007 Port req_op_a_i, req_op_b_i, req_op_c_i  in  C_OP each  operands.
REQ-008 Port op_a_o, op_b_o, op_c_o  out  C_OP each, and rm_o  out  C_RM, prec_o  out  C_PC  shared unit operand bus.
REQ-009 Port addmul_en_o, fma_en_o, div_start_o, sqrt_start_o  out  1 each  single-cycle unit issue strobes.
REQ-010 Port addmul_valid_i, fma_valid_i, divsqrt_valid_i  in  1 each; addmul_result_i, fma_result_i, divsqrt_result_i  in  C_OP each; addmul_flags_i, fma_flags_i, divsqrt_flags_i  in  C_FFLAG each  unit completions.
REQ-011 Port divsqrt_busy_i  in  1  high while the div/sqrt unit is iterating.
REQ-012 Port resp_valid_o  out  1 / resp_ready_i  in  1  response handshake; resp_result_o  out  C_OP, resp_flags_o  out  C_FFLAG, resp_tag_o  out  TAG_WIDTH.
REQ-013 Port err_o  out  1  sticky protocol error.

Function
REQ-014 Op classes: ADDMUL = ADD, SUB, MUL, I2F, F2I; FMA = FMADD, FMSUB, FNMADD, FNMSUB; DIVSQRT = DIV, SQRT; ILL = every other code.
REQ-015 req_ready_o = (credits > 0) AND NOT (class is DIVSQRT AND (divsqrt_busy_i OR a DIVSQRT op is outstanding)); credits = RESP_DEPTH - fifo_count - outstanding.
REQ-016 Accept cycle, combinational: the class strobe is high (DIV -> div_start_o, SQRT -> sqrt_start_o); op_a/b/c_o, rm_o and prec_o carry the request.
REQ-017 Non-accept cycle: op_a/b/c_o, rm_o and prec_o are all-zero (operand isolation); all strobes are low.
REQ-018 Every accept pushes req_tag_i into that class's in-order tag FIFO (depth RESP_DEPTH); outstanding += 1.
REQ-019 An ILL accept completes one cycle later: result 0, flags 5'b10000, its own tag; no unit strobe.
REQ-020 Each unit valid pops its class tag FIFO and writes {result, flags, tag} to the response FIFO in the same edge; outstanding -= 1.
REQ-021 The response FIFO accepts up to 4 writes per cycle; write order is DIVSQRT, ADDMUL, FMA, ILL; the credit rule guarantees space.
REQ-022 resp_valid_o = fifo_count != 0; resp_*_o show the head entry; a pop occurs when resp_valid_o AND resp_ready_i.
REQ-023 resp_*_o are stable while resp_valid_o is high and resp_ready_i is low.
REQ-024 A same-cycle pop and writes are both applied; the freed entry is usable as credit from the next cycle.
REQ-025 Responses within one class leave in issue order; across classes the order is by completion cycle, then REQ-021 order.
REQ-026 A unit valid with an empty class tag FIFO sets err_o and writes nothing; err_o clears only on reset.
REQ-027 Latency: response visible the cycle after the unit valid (ILL: 2 cycles after accept) when the FIFO is empty.

Reset
REQ-028 rst_ni low asynchronously clears the FIFO, tag FIFOs, outstanding count, ILL stage and err_o.
REQ-029 During reset resp_valid_o=0, err_o=0, all strobes=0, operand bus=0.
REQ-030 Reset in mid-operation discards all in-flight tags; unit completions after reset release with empty tag FIFOs set err_o.
REQ-031 After reset, req_ready_o=1 unless divsqrt_busy_i is high for a DIVSQRT request.

Verification
REQ-032 ADD tag 3, unit valid 2 cycles later with 0x40400000, flags 0, resp_ready_i=1 -> resp 0x40400000, tag 3, one cycle after the valid.
REQ-033 DIV tag 1 accepted, then a second DIV presented -> req_ready_o=0 until DIV tag 1 completes; one SQRT issued afterwards -> sqrt_start_o exactly once.
REQ-034 Same-cycle divsqrt, addmul and fma valids (tags 5, 6, 7) -> responses in tag order 5, 6, 7.
REQ-035 resp_ready_i=0, 8 ADDs issued and completed -> the 9th request sees req_ready_o=0; one pop -> req_ready_o=1 the next cycle.
REQ-036 Op code outside every class, tag 2 -> resp result 0, flags 5'b10000, tag 2, two cycles after accept.
REQ-037 addmul_valid_i pulsed with nothing outstanding -> err_o=1 and stays 1; rst_ni low -> err_o=0 and resp_valid_o=0.

Source files
------------

// File: rtl/fpu_issue_ctrl.sv
// FPU issue controller: decodes requests into add/mul, FMA, div/sqrt or illegal classes,
// tracks in-flight tags per class and reorders unit completions into a response FIFO.
module fpu_issue_ctrl #(
  parameter int TAG_WIDTH  = 4,
  parameter int RESP_DEPTH = 8,
  localparam int C_CMD   = 4,
  localparam int C_RM    = 3,
  localparam int C_PC    = 5,
  localparam int C_OP    = 32,
  localparam int C_FFLAG = 5
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic [C_CMD-1:0]     req_op_i,
  input  logic [C_RM-1:0]      req_rm_i,
  input  logic [C_PC-1:0]      req_prec_i,
  input  logic [TAG_WIDTH-1:0] req_tag_i,
  input  logic [C_OP-1:0]      req_op_a_i,
  input  logic [C_OP-1:0]      req_op_b_i,
  input  logic [C_OP-1:0]      req_op_c_i,
  output logic [C_OP-1:0]      op_a_o,
  output logic [C_OP-1:0]      op_b_o,
  output logic [C_OP-1:0]      op_c_o,
  output logic [C_RM-1:0]      rm_o,
  output logic [C_PC-1:0]      prec_o,
  output logic                 addmul_en_o,
  output logic                 fma_en_o,
  output logic                 div_start_o,
  output logic                 sqrt_start_o,
  input  logic                 addmul_valid_i,
  input  logic                 fma_valid_i,
  input  logic                 divsqrt_valid_i,
  input  logic [C_OP-1:0]      addmul_result_i,
  input  logic [C_OP-1:0]      fma_result_i,
  input  logic [C_OP-1:0]      divsqrt_result_i,
  input  logic [C_FFLAG-1:0]   addmul_flags_i,
  input  logic [C_FFLAG-1:0]   fma_flags_i,
  input  logic [C_FFLAG-1:0]   divsqrt_flags_i,
  input  logic                 divsqrt_busy_i,
  output logic                 resp_valid_o,
  input  logic                 resp_ready_i,
  output logic [C_OP-1:0]      resp_result_o,
  output logic [C_FFLAG-1:0]   resp_flags_o,
  output logic [TAG_WIDTH-1:0] resp_tag_o,
  output logic                 err_o
);

  localparam logic [C_CMD-1:0] OP_ADD = 4'd0, OP_SUB = 4'd1, OP_MUL = 4'd2, OP_DIV = 4'd3,
    OP_SQRT = 4'd4, OP_I2F = 4'd5, OP_F2I = 4'd6, OP_FMADD = 4'd7, OP_FMSUB = 4'd8,
    OP_FNMADD = 4'd9, OP_FNMSUB = 4'd10;
  localparam int PW = $clog2(RESP_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [PW-1:0] P_ONE = 1;
  localparam logic [CW-1:0] C_ONE = 1;

  // Class index doubles as the tag FIFO index for the three real units.
  typedef enum logic [1:0] {CLS_ADDMUL = 2'd0, CLS_FMA = 2'd1, CLS_DIVSQRT = 2'd2, CLS_ILL = 2'd3} cls_e;

  cls_e                 cls;
  logic                 accept;
  logic [CW-1:0]        credits;
  logic [2:0]           unit_vld, popped;
  logic [TAG_WIDTH-1:0] pop_tag [3];
  logic [3:0]           s_en;
  logic [C_OP-1:0]      s_res [4];
  logic [C_FFLAG-1:0]   s_flg [4];
  logic [TAG_WIDTH-1:0] s_tag [4];
  logic [PW-1:0]        wp;
  logic [2:0]           nwr;
  logic                 resp_pop;

  logic [TAG_WIDTH-1:0] tq_mem_q [3][RESP_DEPTH], tq_mem_d [3][RESP_DEPTH];
  logic [PW-1:0]        tq_wr_q [3], tq_wr_d [3], tq_rd_q [3], tq_rd_d [3];
  logic [CW-1:0]        tq_cnt_q [3], tq_cnt_d [3];
  logic [C_OP-1:0]      rs_res_q [RESP_DEPTH], rs_res_d [RESP_DEPTH];
  logic [C_FFLAG-1:0]   rs_flg_q [RESP_DEPTH], rs_flg_d [RESP_DEPTH];
  logic [TAG_WIDTH-1:0] rs_tag_q [RESP_DEPTH], rs_tag_d [RESP_DEPTH];
  logic [PW-1:0]        rs_wr_q, rs_wr_d, rs_rd_q, rs_rd_d;
  logic [CW-1:0]        rs_cnt_q, rs_cnt_d, outst_q, outst_d;
  logic                 ill_vld_q, ill_vld_d, err_q, err_d;
  logic [TAG_WIDTH-1:0] ill_tag_q, ill_tag_d;

  always_comb begin
    cls = CLS_ILL;
    case (req_op_i)
      OP_ADD, OP_SUB, OP_MUL, OP_I2F, OP_F2I:   cls = CLS_ADDMUL;
      OP_FMADD, OP_FMSUB, OP_FNMADD, OP_FNMSUB: cls = CLS_FMA;
      OP_DIV, OP_SQRT:                          cls = CLS_DIVSQRT;
      default:                                  cls = CLS_ILL;
    endcase
  end

  // Credits count both queued responses and everything still in flight.
  assign credits     = CW'(RESP_DEPTH) - rs_cnt_q - outst_q;
  assign req_ready_o = (credits != '0) &&
                       !(cls == CLS_DIVSQRT && (divsqrt_busy_i || tq_cnt_q[CLS_DIVSQRT] != '0));
  assign accept      = req_valid_i && req_ready_o && rst_ni;

  assign addmul_en_o  = accept && cls == CLS_ADDMUL;
  assign fma_en_o     = accept && cls == CLS_FMA;
  assign div_start_o  = accept && req_op_i == OP_DIV;
  assign sqrt_start_o = accept && req_op_i == OP_SQRT;
  assign op_a_o = accept ? req_op_a_i : '0;
  assign op_b_o = accept ? req_op_b_i : '0;
  assign op_c_o = accept ? req_op_c_i : '0;
  assign rm_o   = accept ? req_rm_i   : '0;
  assign prec_o = accept ? req_prec_i : '0;

  assign unit_vld = {divsqrt_valid_i, fma_valid_i, addmul_valid_i};

  always_comb begin
    tq_mem_d = tq_mem_q;
    tq_wr_d  = tq_wr_q;
    tq_rd_d  = tq_rd_q;
    tq_cnt_d = tq_cnt_q;
    err_d    = err_q;
    popped   = '0;
    for (int c = 0; c < 3; c++) begin
      pop_tag[c] = tq_mem_q[c][tq_rd_q[c]];
      if (unit_vld[c]) begin
        if (tq_cnt_q[c] == '0) begin
          err_d = 1'b1;
        end else begin
          popped[c]   = 1'b1;
          tq_rd_d[c]  = tq_rd_q[c] + P_ONE;
          tq_cnt_d[c] = tq_cnt_q[c] - C_ONE;
        end
      end
    end
    if (accept && cls != CLS_ILL) begin
      tq_mem_d[cls][tq_wr_q[cls]] = req_tag_i;
      tq_wr_d[cls]  = tq_wr_q[cls] + P_ONE;
      tq_cnt_d[cls] = tq_cnt_d[cls] + C_ONE;
    end
  end

  // Write slots in fixed priority order: div/sqrt, add/mul, FMA, illegal.
  always_comb begin
    s_en = {ill_vld_q, popped[1], popped[0], popped[2]};
    s_res[0] = divsqrt_result_i; s_flg[0] = divsqrt_flags_i; s_tag[0] = pop_tag[2];
    s_res[1] = addmul_result_i;  s_flg[1] = addmul_flags_i;  s_tag[1] = pop_tag[0];
    s_res[2] = fma_result_i;     s_flg[2] = fma_flags_i;     s_tag[2] = pop_tag[1];
    s_res[3] = '0;               s_flg[3] = 5'b10000;        s_tag[3] = ill_tag_q;
    rs_res_d = rs_res_q;
    rs_flg_d = rs_flg_q;
    rs_tag_d = rs_tag_q;
    wp  = rs_wr_q;
    nwr = '0;
    for (int s = 0; s < 4; s++) begin
      if (s_en[s]) begin
        rs_res_d[wp] = s_res[s];
        rs_flg_d[wp] = s_flg[s];
        rs_tag_d[wp] = s_tag[s];
        wp  = wp + P_ONE;
        nwr = nwr + 3'd1;
      end
    end
    rs_wr_d   = wp;
    resp_pop  = (rs_cnt_q != '0) && resp_ready_i;
    rs_rd_d   = rs_rd_q + (resp_pop ? P_ONE : '0);
    rs_cnt_d  = rs_cnt_q + CW'(nwr) - (resp_pop ? C_ONE : '0);
    outst_d   = outst_q + (accept ? C_ONE : '0) - CW'(nwr);
    ill_vld_d = accept && cls == CLS_ILL;
    ill_tag_d = req_tag_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tq_mem_q  <= '{default: '0};
      tq_wr_q   <= '{default: '0};
      tq_rd_q   <= '{default: '0};
      tq_cnt_q  <= '{default: '0};
      rs_res_q  <= '{default: '0};
      rs_flg_q  <= '{default: '0};
      rs_tag_q  <= '{default: '0};
      rs_wr_q   <= '0;
      rs_rd_q   <= '0;
      rs_cnt_q  <= '0;
      outst_q   <= '0;
      ill_vld_q <= 1'b0;
      ill_tag_q <= '0;
      err_q     <= 1'b0;
    end else begin
      tq_mem_q  <= tq_mem_d;
      tq_wr_q   <= tq_wr_d;
      tq_rd_q   <= tq_rd_d;
      tq_cnt_q  <= tq_cnt_d;
      rs_res_q  <= rs_res_d;
      rs_flg_q  <= rs_flg_d;
      rs_tag_q  <= rs_tag_d;
      rs_wr_q   <= rs_wr_d;
      rs_rd_q   <= rs_rd_d;
      rs_cnt_q  <= rs_cnt_d;
      outst_q   <= outst_d;
      ill_vld_q <= ill_vld_d;
      ill_tag_q <= ill_tag_d;
      err_q     <= err_d;
    end
  end

  assign resp_valid_o  = rs_cnt_q != '0;
  assign resp_result_o = rs_res_q[rs_rd_q];
  assign resp_flags_o  = rs_flg_q[rs_rd_q];
  assign resp_tag_o    = rs_tag_q[rs_rd_q];
  assign err_o         = err_q;

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// Bench for fpu_issue_ctrl: directed scenarios then random traffic, all checked against a
// queue-based model of the issue/credit/completion rules.
module tb_fpu_issue_ctrl;

  localparam int DEPTH = 8;
  localparam logic [3:0] OP_ADD = 4'd0, OP_SUB = 4'd1, OP_MUL = 4'd2, OP_DIV = 4'd3,
    OP_SQRT = 4'd4, OP_I2F = 4'd5, OP_F2I = 4'd6, OP_FMADD = 4'd7, OP_FMSUB = 4'd8,
    OP_FNMADD = 4'd9, OP_FNMSUB = 4'd10;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic        req_valid, resp_ready, ds_busy;
  logic [3:0]  req_op, req_tag;
  logic [2:0]  req_rm;
  logic [4:0]  req_prec;
  logic [31:0] req_a, req_b, req_c;
  logic        am_valid, fma_valid, ds_valid;
  logic [31:0] am_res, fma_res, ds_res;
  logic [4:0]  am_flg, fma_flg, ds_flg;

  logic        req_ready_o, addmul_en_o, fma_en_o, div_start_o, sqrt_start_o;
  logic [31:0] op_a_o, op_b_o, op_c_o, resp_result_o;
  logic [2:0]  rm_o;
  logic [4:0]  prec_o, resp_flags_o;
  logic [3:0]  resp_tag_o;
  logic        resp_valid_o, err_o;

  fpu_issue_ctrl #(.TAG_WIDTH(4), .RESP_DEPTH(DEPTH)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready_o),
    .req_op_i(req_op), .req_rm_i(req_rm), .req_prec_i(req_prec), .req_tag_i(req_tag),
    .req_op_a_i(req_a), .req_op_b_i(req_b), .req_op_c_i(req_c),
    .op_a_o(op_a_o), .op_b_o(op_b_o), .op_c_o(op_c_o), .rm_o(rm_o), .prec_o(prec_o),
    .addmul_en_o(addmul_en_o), .fma_en_o(fma_en_o),
    .div_start_o(div_start_o), .sqrt_start_o(sqrt_start_o),
    .addmul_valid_i(am_valid), .fma_valid_i(fma_valid), .divsqrt_valid_i(ds_valid),
    .addmul_result_i(am_res), .fma_result_i(fma_res), .divsqrt_result_i(ds_res),
    .addmul_flags_i(am_flg), .fma_flags_i(fma_flg), .divsqrt_flags_i(ds_flg),
    .divsqrt_busy_i(ds_busy),
    .resp_valid_o(resp_valid_o), .resp_ready_i(resp_ready),
    .resp_result_o(resp_result_o), .resp_flags_o(resp_flags_o), .resp_tag_o(resp_tag_o),
    .err_o(err_o)
  );

  always #5 clk = ~clk;

  // Model state: per-class tag queues, expected responses {result, flags, tag}.
  logic [40:0] exp_q[$];
  logic [3:0]  am_q[$], fma_q[$], ds_q[$], seen_q[$];
  int          m_out, sqrt_cnt, checks, failures;
  logic        m_err, ill_pend;
  logic [3:0]  ill_tag;

  function automatic int op_class(input logic [3:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_MUL, OP_I2F, OP_F2I:   return 0;
      OP_FMADD, OP_FMSUB, OP_FNMADD, OP_FNMSUB: return 1;
      OP_DIV, OP_SQRT:                          return 2;
      default:                                  return 3;
    endcase
  endfunction

  function automatic logic model_ready();
    int credits = DEPTH - exp_q.size() - m_out;
    return (credits > 0) && !(op_class(req_op) == 2 && (ds_busy || ds_q.size() != 0));
  endfunction

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: got %0h expected %0h", name, obs, exp);
    end
  endtask

  task automatic model_clear();
    exp_q.delete(); am_q.delete(); fma_q.delete(); ds_q.delete();
    m_out = 0; m_err = 1'b0; ill_pend = 1'b0; ill_tag = '0;
  endtask

  task automatic idle();
    req_valid = 1'b0; req_op = OP_ADD; req_tag = '0; req_rm = '0; req_prec = '0;
    req_a = '0; req_b = '0; req_c = '0;
    am_valid = 1'b0; fma_valid = 1'b0; ds_valid = 1'b0; ds_busy = 1'b0; resp_ready = 1'b1;
    am_res = $urandom; fma_res = $urandom; ds_res = $urandom;
    am_flg = 5'($urandom); fma_flg = 5'($urandom); ds_flg = 5'($urandom);
  endtask

  task automatic set_req(input logic [3:0] op, input logic [3:0] tag);
    req_valid = 1'b1; req_op = op; req_tag = tag;
    req_a = $urandom; req_b = $urandom; req_c = $urandom;
    req_rm = 3'($urandom_range(0, 7)); req_prec = 5'($urandom_range(0, 31));
  endtask

  // Called at a falling edge with inputs set: check outputs, then advance the model one edge.
  task automatic cycle();
    logic        mready, acc;
    int          cls;
    logic [40:0] head;
    logic [40:0] nq[$];
    #1;
    mready = model_ready();
    acc    = req_valid && mready;
    cls    = op_class(req_op);
    chk("req_ready", req_ready_o, mready);
    chk("resp_valid", resp_valid_o, exp_q.size() != 0);
    if (exp_q.size() != 0) begin
      head = exp_q[0];
      chk("resp_result", resp_result_o, head[40:9]);
      chk("resp_flags", resp_flags_o, head[8:4]);
      chk("resp_tag", resp_tag_o, head[3:0]);
    end
    chk("err", err_o, m_err);
    chk("addmul_en", addmul_en_o, acc && cls == 0);
    chk("fma_en", fma_en_o, acc && cls == 1);
    chk("div_start", div_start_o, acc && req_op == OP_DIV);
    chk("sqrt_start", sqrt_start_o, acc && req_op == OP_SQRT);
    chk("op_a", op_a_o, acc ? req_a : 32'h0);
    chk("op_b", op_b_o, acc ? req_b : 32'h0);
    chk("op_c", op_c_o, acc ? req_c : 32'h0);
    chk("rm", rm_o, acc ? req_rm : 3'h0);
    chk("prec", prec_o, acc ? req_prec : 5'h0);
    if (sqrt_start_o === 1'b1) sqrt_cnt++;
    if (resp_valid_o === 1'b1 && resp_ready) seen_q.push_back(resp_tag_o);
    if (ds_valid) begin
      if (ds_q.size() != 0) nq.push_back({ds_res, ds_flg, ds_q.pop_front()});
      else m_err = 1'b1;
    end
    if (am_valid) begin
      if (am_q.size() != 0) nq.push_back({am_res, am_flg, am_q.pop_front()});
      else m_err = 1'b1;
    end
    if (fma_valid) begin
      if (fma_q.size() != 0) nq.push_back({fma_res, fma_flg, fma_q.pop_front()});
      else m_err = 1'b1;
    end
    if (ill_pend) nq.push_back({32'h0, 5'b10000, ill_tag});
    if (exp_q.size() != 0 && resp_ready) void'(exp_q.pop_front());
    foreach (nq[i]) exp_q.push_back(nq[i]);
    m_out -= nq.size();
    ill_pend = acc && cls == 3;
    ill_tag  = req_tag;
    if (acc) begin
      m_out++;
      case (cls)
        0: am_q.push_back(req_tag);
        1: fma_q.push_back(req_tag);
        2: ds_q.push_back(req_tag);
        default: ;
      endcase
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    idle();
    rst_n = 1'b0;
    set_req(OP_ADD, 4'd1);
    #1;
    chk("rst_resp_valid", resp_valid_o, 1'b0);
    chk("rst_err", err_o, 1'b0);
    chk("rst_strobes", {addmul_en_o, fma_en_o, div_start_o, sqrt_start_o}, 4'b0);
    chk("rst_op_bus", {op_a_o, rm_o, prec_o}, '0);
    @(negedge clk);
    @(negedge clk);
    model_clear();
    idle();
    rst_n = 1'b1;
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || m_out != 0) && n < 200) begin
      idle();
      am_valid = am_q.size() != 0; fma_valid = fma_q.size() != 0; ds_valid = ds_q.size() != 0;
      cycle();
      n++;
    end
    idle();
    chk("drain_bound", n < 200, 1'b1);
  endtask

  initial begin
    checks = 0; failures = 0; sqrt_cnt = 0;
    model_clear();
    idle();
    @(negedge clk);
    do_reset();
    #1 chk("post_reset_ready", req_ready_o, 1'b1);
    cycle();

    // Single ADD, unit result two cycles after issue.
    set_req(OP_ADD, 4'd3); cycle();
    idle(); cycle();
    am_valid = 1'b1; am_res = 32'h40400000; am_flg = 5'h0; cycle();
    idle();
    #1;
    chk("add_resp_valid", resp_valid_o, 1'b1);
    chk("add_resp_result", resp_result_o, 32'h40400000);
    chk("add_resp_tag", resp_tag_o, 4'd3);
    cycle();
    drain();

    // DIV blocks a second DIV until it completes; then one SQRT.
    sqrt_cnt = 0;
    set_req(OP_DIV, 4'd1); cycle();
    set_req(OP_DIV, 4'd2); ds_busy = 1'b1;
    #1 chk("div2_blocked", req_ready_o, 1'b0);
    for (int i = 0; i < 3; i++) cycle();
    ds_busy = 1'b0; ds_valid = 1'b1; cycle();
    ds_valid = 1'b0;
    set_req(OP_SQRT, 4'd3);
    #1 chk("sqrt_ready", req_ready_o, 1'b1);
    cycle();
    idle(); ds_busy = 1'b1; cycle(); cycle();
    ds_busy = 1'b0; ds_valid = 1'b1; cycle();
    drain();
    chk("sqrt_once", sqrt_cnt, 1);

    // Same-cycle completions from all three units.
    set_req(OP_DIV, 4'd5); cycle();
    set_req(OP_ADD, 4'd6); cycle();
    set_req(OP_FMADD, 4'd7); cycle();
    idle(); cycle();
    seen_q.delete();
    ds_valid = 1'b1; am_valid = 1'b1; fma_valid = 1'b1; cycle();
    drain();
    chk("order_count", seen_q.size(), 3);
    if (seen_q.size() >= 3) begin
      chk("order_0", seen_q[0], 4'd5);
      chk("order_1", seen_q[1], 4'd6);
      chk("order_2", seen_q[2], 4'd7);
    end

    // Fill the response FIFO with resp_ready low.
    for (int i = 0; i < 8; i++) begin
      idle(); resp_ready = 1'b0; set_req(OP_ADD, 4'(i)); cycle();
    end
    for (int i = 0; i < 8; i++) begin
      idle(); resp_ready = 1'b0; am_valid = 1'b1; cycle();
    end
    idle(); resp_ready = 1'b0; set_req(OP_ADD, 4'd9);
    #1 chk("full_not_ready", req_ready_o, 1'b0);
    cycle();
    resp_ready = 1'b1;
    #1 chk("pop_cycle_not_ready", req_ready_o, 1'b0);
    cycle();
    resp_ready = 1'b0;
    #1 chk("after_pop_ready", req_ready_o, 1'b1);
    cycle();
    drain();

    // Illegal op code completes on its own two cycles after accept.
    set_req(4'd13, 4'd2); cycle();
    idle(); cycle();
    #1;
    chk("ill_valid", resp_valid_o, 1'b1);
    chk("ill_result", resp_result_o, 32'h0);
    chk("ill_flags", resp_flags_o, 5'b10000);
    chk("ill_tag", resp_tag_o, 4'd2);
    cycle();
    drain();

    // Spurious completion is a sticky error.
    am_valid = 1'b1; cycle();
    idle(); cycle(); cycle(); cycle();
    #1 chk("err_sticky", err_o, 1'b1);
    do_reset();
    cycle();

    // Random traffic.
    for (int n = 0; n < 1500; n++) begin
      idle();
      if ($urandom_range(0, 1) == 1) set_req(4'($urandom_range(0, 15)), 4'($urandom));
      am_valid  = am_q.size() != 0 && $urandom_range(0, 2) == 0;
      fma_valid = fma_q.size() != 0 && $urandom_range(0, 2) == 0;
      ds_valid  = ds_q.size() != 0 && $urandom_range(0, 3) == 0;
      ds_busy   = $urandom_range(0, 3) == 0;
      resp_ready = $urandom_range(0, 3) != 0;
      cycle();
    end
    drain();
    #1 chk("random_drained", resp_valid_o, 1'b0);
    cycle();

    // Reset with work in flight; a late completion then finds no tag.
    set_req(OP_ADD, 4'd4); cycle();
    set_req(OP_FMADD, 4'd8); cycle();
    do_reset();
    am_valid = 1'b1; cycle();
    idle();
    #1 chk("late_completion_err", err_o, 1'b1);
    cycle();
    do_reset();
    cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
